// File: rtl/mem_timer_responder_if.sv
// MEM-port bus between the core and the timer responder.
// Enable, byte strobes, address, write data, read data and interrupt.
interface mem_timer_responder_if;
  logic        en_i;
  logic [3:0]  write_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        irq_o;

  modport master (
    output en_i,
    output write_i,
    output addr_i,
    output data_i,
    input  data_o,
    input  irq_o
  );

  modport slave (
    input  en_i,
    input  write_i,
    input  addr_i,
    input  data_i,
    output data_o,
    output irq_o
  );
endinterface

// File: rtl/mem_timer_responder.sv
// Memory-mapped 32-bit timer responder on the MEM data port.
// Optional prescaler enabled by defining TIMER_PRESCALE_EN.
module mem_timer_responder #(
  parameter logic [31:0] BASE_ADDR     = 32'h0001_0000,
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic                 clk,
  input  logic                 rst_i,
  mem_timer_responder_if.slave bus
);

  localparam logic [2:0] OFF_CTRL  = 3'd0;
  localparam logic [2:0] OFF_COUNT = 3'd1;
  localparam logic [2:0] OFF_CMP   = 3'd2;
  localparam logic [2:0] OFF_STAT  = 3'd3;
  localparam logic [2:0] OFF_PRESC = 3'd4;

  function automatic logic [31:0] merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  strb
  );
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      r[8*k +: 8] = strb[k] ? new_v[8*k +: 8]
                            : old_v[8*k +: 8];
    end
    return r;
  endfunction

  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic        match_q, match_d;
  logic [31:0] rdata;
  logic [31:0] data_q;

  logic        hit, wr, rd;
  logic [2:0]  off;
  logic        tick, at_cmp;
  logic [31:0] ticked;
  logic [31:0] ctrl_m;

  assign hit = bus.en_i &&
               (bus.addr_i[31:5] == BASE_ADDR[31:5]);
  assign off = bus.addr_i[4:2];
  assign wr  = hit && (bus.write_i != 4'b0000);
  assign rd  = hit && (bus.write_i == 4'b0000);

  assign at_cmp = (count_q == cmp_q);

`ifdef TIMER_PRESCALE_EN
  logic [15:0] presc_q, presc_d;
  logic [15:0] psc_q, psc_d;
  logic [31:0] presc_m;

  assign tick = ctrl_q[0] && (psc_q == presc_q);

  // Prescale counter and PRESC register next-state.
  always_comb begin
    presc_m = merge({16'h0, presc_q}, bus.data_i,
                    bus.write_i);
    presc_d = presc_q;
    if (wr && off == OFF_PRESC) presc_d = presc_m[15:0];
    psc_d = psc_q + 16'd1;
    if (!ctrl_q[0] || tick) psc_d = 16'd0;
  end

  // Prescaler state register.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      presc_q <= 16'd0;
      psc_q   <= 16'd0;
    end else begin
      presc_q <= presc_d;
      psc_q   <= psc_d;
    end
  end
`else
  assign tick = ctrl_q[0];
`endif

  // Counter, match and software write next-state.
  always_comb begin
    ticked = count_q;
    if (tick) begin
      if (at_cmp && ctrl_q[1]) ticked = 32'd0;
      else                     ticked = count_q + 32'd1;
    end

    count_d = ticked;
    if (wr && off == OFF_COUNT)
      count_d = merge(ticked, bus.data_i, bus.write_i);

    ctrl_m = merge({29'h0, ctrl_q}, bus.data_i,
                   bus.write_i);
    ctrl_d = ctrl_q;
    if (wr && off == OFF_CTRL) ctrl_d = ctrl_m[2:0];

    cmp_d = cmp_q;
    if (wr && off == OFF_CMP)
      cmp_d = merge(cmp_q, bus.data_i, bus.write_i);

    match_d = match_q;
    if (wr && off == OFF_STAT && bus.write_i[0] &&
        bus.data_i[0])
      match_d = 1'b0;
    if (tick && at_cmp) match_d = 1'b1;
  end

  // Read data mux from pre-update register values.
  always_comb begin
    rdata = 32'd0;
    case (off)
      OFF_CTRL:  rdata = {29'h0, ctrl_q};
      OFF_COUNT: rdata = count_q;
      OFF_CMP:   rdata = cmp_q;
      OFF_STAT:  rdata = {31'h0, match_q};
`ifdef TIMER_PRESCALE_EN
      OFF_PRESC: rdata = {16'h0, presc_q};
`endif
      default:   rdata = 32'd0;
    endcase
  end

  // Timer register file and registered read data.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      ctrl_q  <= 3'd0;
      count_q <= 32'd0;
      cmp_q   <= RESET_COMPARE;
      match_q <= 1'b0;
      data_q  <= 32'd0;
    end else begin
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
      if (rd) data_q <= rdata;
    end
  end

  assign bus.data_o = data_q;
  assign bus.irq_o  = match_q & ctrl_q[2];

endmodule

// File: tb/tb_mem_timer_responder.sv
// Directed self-checking bench for mem_timer_responder.
// Tasks start and end on a falling clock edge.
module tb_mem_timer_responder;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic clk;
  logic rst_i;
  int   checks;
  int   failures;

  mem_timer_responder_if bus();

  mem_timer_responder #(
    .BASE_ADDR     (BASE),
    .RESET_COMPARE (32'hFFFF_FFFF)
  ) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [3:0] s,
                    input logic [31:0] d);
    bus.en_i    = 1'b1;
    bus.write_i = s;
    bus.addr_i  = a;
    bus.data_i  = d;
    @(negedge clk);
    bus.en_i    = 1'b0;
    bus.write_i = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a,
                    output logic [31:0] d);
    bus.en_i    = 1'b1;
    bus.write_i = 4'h0;
    bus.addr_i  = a;
    @(negedge clk);
    bus.en_i    = 1'b0;
    d = bus.data_o;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle(2);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] exp_v [4];
    exp_v = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0};
    bus.en_i = 1'b1;
    bus.write_i = 4'hF;
    bus.addr_i = BASE;
    bus.data_i = 32'h7;
    rst_i = 1'b1;
    idle(2);
    bus.en_i = 1'b0;
    bus.write_i = 4'h0;
    rst_i = 1'b0;
    checks++;
    if (bus.data_o !== 32'h0 || bus.irq_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_out data=%h irq=%b want 0/0",
               bus.data_o, bus.irq_o);
    end
    for (int i = 0; i < 4; i++) begin
      rd(BASE + 32'(4 * i), v);
      checks++;
      if (v !== exp_v[i]) begin
        failures++;
        $display("FAIL reset_reg%0d got=%h want=%h",
                 i, v, exp_v[i]);
      end
    end
    rd(BASE + 32'h14, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL reserved_rd got=%h want=0", v);
    end
  endtask

  task automatic test_match_reload();
    logic [31:0] v;
    do_reset();
    wr(BASE + 32'h8, 4'hF, 32'd5);
    wr(BASE, 4'hF, 32'h7);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      checks++;
      if (bus.irq_o !== (i == 6)) begin
        failures++;
        $display("FAIL match_irq cyc=%0d got=%b want=%b",
                 i, bus.irq_o, (i == 6));
      end
    end
    for (int i = 0; i < 3; i++) begin
      rd(BASE + 32'h4, v);
      checks++;
      if (v !== 32'(i)) begin
        failures++;
        $display("FAIL reload_cnt got=%h want=%h",
                 v, 32'(i));
      end
    end
    rd(BASE + 32'hC, v);
    checks++;
    if (v !== 32'h1) begin
      failures++;
      $display("FAIL match_stat got=%h want=1", v);
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] v;
    do_reset();
    wr(BASE + 32'h4, 4'hF, 32'h1234_5678);
    wr(BASE + 32'h4, 4'b0010, 32'h0000_AB00);
    rd(BASE + 32'h4, v);
    checks++;
    if (v !== 32'h1234_AB78) begin
      failures++;
      $display("FAIL byte_cnt got=%h want=1234ab78", v);
    end
    wr(BASE + 32'h8, 4'b0001, 32'h5555_55AA);
    rd(BASE + 32'h8, v);
    checks++;
    if (v !== 32'hFFFF_FFAA) begin
      failures++;
      $display("FAIL byte_cmp got=%h want=ffffffaa", v);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] v;
    do_reset();
    wr(BASE + 32'h8, 4'hF, 32'd3);
    wr(BASE + 32'h4, 4'hF, 32'hFFFF_FFFF);
    wr(BASE, 4'hF, 32'h1);
    idle(1);
    rd(BASE + 32'h4, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL wrap_cnt got=%h want=0", v);
    end
    rd(BASE + 32'hC, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL wrap_nomatch got=%h want=0", v);
    end
    idle(2);
    rd(BASE + 32'hC, v);
    checks++;
    if (v !== 32'h1 || bus.irq_o !== 1'b0) begin
      failures++;
      $display("FAIL wrap_match got=%h irq=%b want=1/0",
               v, bus.irq_o);
    end
  endtask

  task automatic test_w1c();
    logic [31:0] v;
    do_reset();
    wr(BASE + 32'h8, 4'hF, 32'd2);
    wr(BASE, 4'hF, 32'h7);
    idle(2);
    wr(BASE + 32'hC, 4'h1, 32'h1);
    wr(BASE, 4'hF, 32'h4);
    checks++;
    if (bus.irq_o !== 1'b1) begin
      failures++;
      $display("FAIL w1c_race irq=%b want=1", bus.irq_o);
    end
    wr(BASE + 32'hC, 4'hF, 32'h0);
    checks++;
    if (bus.irq_o !== 1'b1) begin
      failures++;
      $display("FAIL w1c_zero irq=%b want=1", bus.irq_o);
    end
    wr(BASE + 32'hC, 4'h1, 32'h1);
    checks++;
    if (bus.irq_o !== 1'b0) begin
      failures++;
      $display("FAIL w1c_clr irq=%b want=0", bus.irq_o);
    end
    rd(BASE + 32'hC, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL w1c_stat got=%h want=0", v);
    end
  endtask

  task automatic test_miss();
    logic [31:0] v;
    do_reset();
    rd(BASE + 32'h8, v);
    wr(BASE + 32'h20, 4'hF, 32'h7);
    wr(BASE + 32'h24, 4'hF, 32'h1234);
    checks++;
    if (bus.data_o !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL miss_hold got=%h want=ffffffff",
               bus.data_o);
    end
    rd(BASE + 32'h20, v);
    checks++;
    if (v !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL miss_rd got=%h want=ffffffff", v);
    end
    wr(BASE + 32'h14, 4'hF, 32'hDEAD_BEEF);
    rd(BASE + 32'h14, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL rsvd_wr got=%h want=0", v);
    end
    rd(BASE, v);
    checks++;
    if (v !== 32'h0 || bus.irq_o !== 1'b0) begin
      failures++;
      $display("FAIL miss_ctrl got=%h want=0", v);
    end
    rd(BASE + 32'h4, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL miss_cnt got=%h want=0", v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    do_reset();
    wr(BASE + 32'h8, 4'hF, 32'h0001_0000);
    wr(BASE + 32'h4, 4'hF, 32'h0000_00FF);
    wr(BASE, 4'hF, 32'h1);
    wr(BASE + 32'h4, 4'b0010, 32'hFFFF_55FF);
    rd(BASE + 32'h4, v);
    checks++;
    if (v !== 32'h0000_5500) begin
      failures++;
      $display("FAIL cnt_tick_wr got=%h want=00005500", v);
    end
  endtask

`ifdef TIMER_PRESCALE_EN
  task automatic test_prescale();
    logic [31:0] v;
    logic [31:0] exp_v [4];
    exp_v = '{32'd0, 32'd1, 32'd1, 32'd2};
    do_reset();
    wr(BASE + 32'h10, 4'hF, 32'hFFFF_0003);
    wr(BASE, 4'hF, 32'h1);
    idle(3);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) idle(2);
      rd(BASE + 32'h4, v);
      checks++;
      if (v !== exp_v[i]) begin
        failures++;
        $display("FAIL presc_cnt%0d got=%h want=%h",
                 i, v, exp_v[i]);
      end
    end
    rd(BASE + 32'h10, v);
    checks++;
    if (v !== 32'h3) begin
      failures++;
      $display("FAIL presc_reg got=%h want=3", v);
    end
  endtask
`else
  task automatic test_prescale();
    logic [31:0] v;
    do_reset();
    wr(BASE + 32'h10, 4'hF, 32'h0000_0003);
    rd(BASE + 32'h10, v);
    checks++;
    if (v !== 32'h0) begin
      failures++;
      $display("FAIL presc_off got=%h want=0", v);
    end
  endtask
`endif

  initial begin
    checks      = 0;
    failures    = 0;
    rst_i       = 1'b1;
    bus.en_i    = 1'b0;
    bus.write_i = 4'h0;
    bus.addr_i  = 32'h0;
    bus.data_i  = 32'h0;
    @(negedge clk);
    test_reset();
    test_match_reload();
    test_byte_write();
    test_wrap();
    test_w1c();
    test_miss();
    test_back_to_back();
    test_prescale();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_timer_responder.md
Name: mem_timer_responder

Overview:
- Memory-mapped timer peripheral that acts as the responder on the core's MEM data port.
- Uses the same enable/byte-strobe/address/data protocol that the core drives toward the dual-port RAM.
- Provides a free-running 32-bit counter with compare match, auto-reload and an interrupt line.
- Sits beside the RAM on the MEM port; an external decoder steers the MEM-port read data by address window.

Parameters:
BASE_ADDR, 32'h0001_0000, byte address of the register window; bits [4:0] must be zero.
RESET_COMPARE, 32'hFFFF_FFFF, reset value of the COMPARE register.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst_i  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
en_i  input  1  access request from the core MEM port; valid for one cycle per access.
write_i  input  4  byte write strobes; 4'b0000 with en_i=1 is a read.
addr_i  input  32  byte address; bits [1:0] ignored.
data_i  input  32  write data; byte lane k is data_i[8k+7:8k].
data_o  output  32  registered read data.
irq_o  output  1  level interrupt = STATUS.match & CTRL.irq_en.

Behaviour:
- Window hit: en_i=1 and addr_i[31:5]==BASE_ADDR[31:5]. Offset is addr_i[4:2].
- Register map (word offsets):
  - 0x00 CTRL: bit0 enable, bit1 auto_reload, bit2 irq_en; other bits read 0.
  - 0x04 COUNT.
  - 0x08 COMPARE.
  - 0x0C STATUS: bit0 match, write-1-to-clear.
  - 0x10 PRESC: see Optional Feature.
  - 0x14–0x1C: reserved; read 0, writes ignored.
- Reset (rst_i=1 at a clock edge):
  - CTRL=0, COUNT=0, COMPARE=RESET_COMPARE, STATUS=0.
  - data_o=0, irq_o=0.
  - Reset overrides any access presented in the same cycle. Reset mid-count discards all state.
- Writes:
  - Per-byte merge: byte k is updated only where write_i[k]=1.
  - Take effect at the clock edge; visible to a read issued on the following cycle.
- Reads:
  - One-cycle latency. data_o is loaded at the edge ending a read-hit cycle, with the register value from before that edge's update.
  - On any other cycle (idle, write, miss), data_o holds its last value.
  - A miss never loads data_o and never changes state.
- Counting:
  - tick = CTRL.enable, qualified by the prescaler when PRESC is enabled (see Optional Feature).
  - On a tick with COUNT!=COMPARE: COUNT←COUNT+1, wrapping from 32'hFFFF_FFFF to 0.
  - On a tick with COUNT==COMPARE: STATUS.match←1, and COUNT←0 if auto_reload, else COUNT←COUNT+1.
- Simultaneous events:
  - Software write to COUNT in the same cycle as a tick: the written bytes win, unwritten bytes take the ticked value.
  - Match set in the same cycle as a W1C of STATUS: set wins, so match stays 1.
  - Write to COMPARE in the same cycle as a tick: the match test uses the pre-write COMPARE.
- irq_o: combinational from registered state, with no extra latency after STATUS/CTRL update.

Optional Feature:
- Macro TIMER_PRESCALE_EN.
- Defined:
  - PRESC is a 16-bit register at 0x10 (bits [31:16] read 0), reset 0.
  - An internal 16-bit prescale counter increments each enabled cycle.
  - tick fires when the prescale counter == PRESC; the prescale counter then returns to 0.
  - The prescale counter is held at 0 while CTRL.enable=0.
  - PRESC=0 gives a tick every cycle.
- Undefined:
  - tick=CTRL.enable every cycle.
  - 0x10 reads 0 and writes are ignored; no prescaler logic is present.

Test Plan:
- Reset then read 0x00, 0x04, 0x08, 0x0C -> data_o = 0, 0, 32'hFFFF_FFFF, 0 on the cycle after each read; irq_o=0.
- Write COMPARE=5, CTRL=3'b111 -> STATUS.match=1 and irq_o=1 on the 6th enabled cycle; COUNT then reads 0,1,2…
- Byte write COUNT with write_i=4'b0010, data_i=32'h0000_AB00 while COUNT=32'h1234_5678 and enable=0 -> COUNT reads 32'h1234_AB78.
- COUNT=32'hFFFF_FFFF, COMPARE=3, enable, auto_reload=0 -> COUNT reads 0 after one cycle and no match; match is set when COUNT passes 3.
- W1C of STATUS in the same cycle as a new match -> match stays 1; W1C on a later idle cycle -> match=0, irq_o=0.
- Access at BASE_ADDR+0x20 with write_i=4'hF -> no state change; data_o holds its previous value.
- With TIMER_PRESCALE_EN: PRESC=3 -> COUNT increments once every 4 cycles.
